// File: rtl/disp_min_ctrl.sv
// Sequencing controller around the disparity minimum-search datapath: issues cost
// vectors under credit control, tracks in-flight results and frames them as a raster stream.
module disp_min_ctrl #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int MIN_DISP     = 20,
  parameter int DISP_RANGE   = 108,
  parameter int CALC_LAT     = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int INVALID_COLS = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DISP_RANGE*8-1:0] in_cost,
  output logic [DISP_RANGE*8-1:0] calc_cost,
  input  logic [7:0]              calc_min_cost,
  input  logic [7:0]              calc_min_pos,
  output logic                    disp_valid,
  input  logic                    disp_ready,
  output logic [7:0]              disp_out,
  output logic [7:0]              disp_cost,
  output logic                    disp_ok,
  output logic [10:0]             disp_x,
  output logic [9:0]              disp_y,
  output logic                    disp_last,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PIX_W-1:0] PIX_LAST    = PIX_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   CREDITS     = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [10:0]      X_LAST      = 11'(IMG_WIDTH - 1);
  localparam logic [9:0]       Y_LAST      = 10'(IMG_HEIGHT - 1);
  localparam logic [10:0]      X_VALID_MIN = 11'(INVALID_COLS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_next;
  logic [PIX_W-1:0]    in_cnt;
  logic [CALC_LAT-1:0] vld_p;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [15:0]         fifo_mem [FIFO_DEPTH];
  logic [10:0]         out_x;
  logic [9:0]          out_y;

  logic                issue, push, pop, fifo_empty, frame_start;
  logic [CNT_W:0]      credit_used;
  logic [15:0]         head;

  // Pixel offset to disparity; pos + MIN_DISP stays within 8 bits for legal lane counts.
  function automatic logic [7:0] form_disp(input logic [7:0] pos);
    return pos + 8'(MIN_DISP);
  endfunction

  assign calc_cost   = in_cost;
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign in_ready    = (state == RUN) && (credit_used < CREDITS);
  assign issue       = in_valid && in_ready;
  assign push        = vld_p[CALC_LAT-1];
  assign fifo_empty  = (fifo_count == '0);
  assign pop         = !fifo_empty && disp_ready;
  assign frame_start = (state == IDLE) && start;

  // Frame sequencing
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (issue && (in_cnt == PIX_LAST)) state_next = DRAIN;
      DRAIN: if ((inflight == '0) &&
                 (fifo_empty || ((fifo_count == CNT_W'(1)) && pop)))
               state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      in_cnt <= '0;
    end else begin
      state <= state_next;
      if (frame_start)
        in_cnt <= '0;
      else if (issue)
        in_cnt <= in_cnt + PIX_W'(1);
    end
  end

  // Issue -> datapath result boundary: vld_p shadows the CALC_LAT-deep datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p    <= '0;
      inflight <= '0;
    end else begin
      vld_p <= (vld_p << 1) | CALC_LAT'(issue);
      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Datapath result -> output FIFO boundary
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {calc_min_cost, calc_min_pos};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Raster coordinate of the FIFO head
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      out_x <= '0;
      out_y <= '0;
    end else if (pop) begin
      if (out_x == X_LAST) begin
        out_x <= '0;
        out_y <= out_y + 10'd1;
      end else begin
        out_x <= out_x + 11'd1;
      end
    end
  end

  // Output framing; data fields are gated so they read zero while the FIFO is empty
  assign head       = fifo_mem[rd_ptr];
  assign disp_valid = !fifo_empty;
  assign disp_cost  = disp_valid ? head[15:8] : 8'd0;
  assign disp_ok    = disp_valid && (out_x >= X_VALID_MIN) && (head[15:8] != 8'hFF);
  assign disp_out   = disp_ok ? form_disp(head[7:0]) : 8'd0;
  assign disp_x     = out_x;
  assign disp_y     = out_y;
  assign disp_last  = disp_valid && (out_x == X_LAST) && (out_y == Y_LAST);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule
